muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit in the EX stage of the pipelined CPU, with architectural HI/LO registers. It consumes the already-forwarded A/B operands, i.e. the outputs of the EX-stage operand forwarding muxes. While an operation runs it holds `busy` high so the hazard logic can stall IF/ID/EX. Results land in HI/LO for later MFHI/MFLO reads.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, followed by
// a sign-fix cycle that writes HI/LO. busy stalls the pipeline while running.
// Build option: define MULDIV_DIV_EN to compile the divider (DIV/DIVU); when it
// is undefined, DIV/DIVU starts are ignored and only MULT/MULTU/MTHI/MTLO exist.
`timescale 1ns/1ps

module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             wehi,
  input  logic             welo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;    // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0] bq;     // multiplicand magnitude or divisor magnitude
  logic             sa;
  logic             sb;
`ifdef MULDIV_DIV_EN
  logic             is_div;
  logic             dz;     // divisor was zero
`endif

  // Operand magnitudes and start qualification
  logic             sgn_op;
  logic             accept;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    sgn_op = ~op[0];
`ifdef MULDIV_DIV_EN
    accept = start;
`else
    accept = start & ~op[1];
`endif
    abs_a  = (sgn_op && opa[WIDTH-1]) ? -opa : opa;
    abs_b  = (sgn_op && opb[WIDTH-1]) ? -opb : opb;
  end

  // One shift-add multiply step
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, bq} : (WIDTH+1)'(0));
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // One restoring divide step
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [AW-1:0]    div_next;

  always_comb begin
    div_shift = acc[AW-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, bq};
    div_diff  = div_shift[WIDTH-1:0] - bq;
    div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end
`endif

  // Iteration select and sign-corrected final result
  logic [AW-1:0]    step_next;
  logic [AW-1:0]    prod_fix;
  logic [AW-1:0]    result;

  always_comb begin
    prod_fix = (sa ^ sb) ? -acc : acc;
`ifdef MULDIV_DIV_EN
    step_next = is_div ? div_next : mul_next;
    if (is_div) begin
      result[AW-1:WIDTH] = sa ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
      if (dz)
        result[WIDTH-1:0] = '1;
      else
        result[WIDTH-1:0] = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      result = prod_fix;
    end
`else
    step_next = mul_next;
    result    = prod_fix;
`endif
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      bq     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      dz     <= 1'b0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sa    <= sgn_op & opa[WIDTH-1];
            sb    <= sgn_op & opb[WIDTH-1];
`ifdef MULDIV_DIV_EN
            is_div <= op[1];
            dz     <= (opb == '0);
`endif
            if (op[1]) begin
              acc <= {WIDTH'(0), abs_a};
              bq  <= abs_b;
            end else begin
              acc <= {WIDTH'(0), abs_b};
              bq  <= abs_a;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else if (!start) begin
            if (wehi) hi <= wdata;
            if (welo) lo <= wdata;
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= result[AW-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written sequences for muldiv_unit.
`timescale 1ns/1ps

module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         wehi;
  logic         welo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .wehi  (wehi),
    .welo  (welo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Launch one operation and follow it to completion; poke drives spurious
  // start/MTHI/MTLO in mid-CALC and in the FIX cycle, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic lo_we, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit poke);
    int cycles;
    int early_done;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    welo  = lo_we; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; welo = 1'b0;
    opa = 32'h5A5A_5A5A; opb = 32'hA5A5_A5A5;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("lo_hold_at_start", lo, m_lo);
    chk("hi_hold_at_start", hi, m_hi);
    cycles = 0;
    early_done = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (done) early_done++;
      if (poke && (cycles == 5 || cycles == 33)) begin
        start = 1'b1; op = 2'b01; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
        wehi = 1'b1; welo = 1'b1; wdata = 32'h1111_2222;
      end else begin
        start = 1'b0; wehi = 1'b0; welo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; wehi = 1'b0; welo = 1'b0;
    chk("busy_cycles", 32'(cycles), 32'd33);
    chk("early_done", 32'(early_done), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_after_fix", 32'(busy), 32'd0);
  endtask

  // Bounded watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    wehi = 1'b0; welo = 1'b0; wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;

    // MTHI+MTLO together, then MTHI alone
    @(negedge clk); wehi = 1'b1; welo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk); wehi = 1'b0; welo = 1'b0;
    m_hi = 32'hA5A5_0F0F; m_lo = 32'hA5A5_0F0F;
    chk("mthi_mtlo_hi", hi, m_hi);
    chk("mthi_mtlo_lo", lo, m_lo);
    wehi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); wehi = 1'b0;
    m_hi = 32'h0000_1234;
    chk("mthi_hi", hi, m_hi);
    chk("mthi_lo_keep", lo, m_lo);

    // MULTU 5*6 with MTLO in the start cycle: the MTLO is dropped
    run_op(2'b01, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 1'b0);

    // Directed vector table
    vecs.push_back('{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'b00, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD});
    vecs.push_back('{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
    vecs.push_back('{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_hi, vecs[i].exp_lo, (i % 2) == 0);

`ifndef MULDIV_DIV_EN
    // DIV start without the divider: ignored entirely
    @(negedge clk); start = 1'b1; op = 2'b10; opa = 32'd9; opb = 32'd3;
    @(negedge clk); start = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done) bad++;
      @(negedge clk);
    end
    chk("nodiv_busy_done", 32'(bad), 32'd0);
    chk("nodiv_hi", hi, m_hi);
    chk("nodiv_lo", lo, m_lo);
`endif

    // Reset at CALC iteration 10
    @(negedge clk);
    start = 1'b1; opa = 32'd100; opb = 32'd7;
`ifdef MULDIV_DIV_EN
    op = 2'b10;
`else
    op = 2'b01;
`endif
    @(negedge clk); start = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done) bad++;
      @(negedge clk);
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    run_op(2'b01, 32'd2, 32'd3, 1'b0, 32'd0, 32'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
